// File: rtl/interrupt_request_register_8259a.sv
// Interrupt Request Register for an 8259A-compatible interrupt controller.
// This block samples IR7..IR0 into pending-request bits in level or edge mode.
// Each bit has an edge-arm latch. The latch is set whenever the pin is seen low,
// so a request in edge mode needs a real low-to-high transition on the pin.
module interrupt_request_register_8259a (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       level_or_edge_triggered_config,
    input  logic       freeze,
    input  logic [7:0] clear_interrupt_request,
    input  logic [7:0] interrupt_request_pin,
    output logic [7:0] interrupt_request_register
);

    logic [7:0] r_edge_arm;
    logic [7:0] r_irr;
    logic [7:0] w_edge_request;
    logic [7:0] w_sample;
    logic [7:0] w_irr_next;

    // Arm latch: a clear disarms the bit; a low pin arms it; a high pin holds it.
    // The latch keeps updating during freeze and in level mode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_arm <= 8'h00;
        end else begin
            r_edge_arm <= ~clear_interrupt_request & (r_edge_arm | ~interrupt_request_pin);
        end
    end

    // Select the next register value: clear overrides freeze, and freeze overrides sampling.
    always_comb begin
        w_edge_request = r_edge_arm & interrupt_request_pin;
        w_sample       = level_or_edge_triggered_config ? interrupt_request_pin : w_edge_request;
        w_irr_next     = freeze ? r_irr : w_sample;
        w_irr_next     = w_irr_next & ~clear_interrupt_request;
    end

    // Pending-request register. It is read only from the flop, so no input reaches the output combinationally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irr <= 8'h00;
        end else begin
            r_irr <= w_irr_next;
        end
    end

    assign interrupt_request_register = r_irr;

endmodule

// File: tb/tb_interrupt_request_register_8259a.sv
// Directed testbench for the 8259A interrupt request register.
// Expected values are computed by hand from the intended behaviour.
module tb_interrupt_request_register_8259a;

    logic       clock;
    logic       reset_n;
    logic       level_or_edge_triggered_config;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
    logic [7:0] interrupt_request_pin;
    logic [7:0] interrupt_request_register;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_request_register_8259a dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .level_or_edge_triggered_config (level_or_edge_triggered_config),
        .freeze                         (freeze),
        .clear_interrupt_request        (clear_interrupt_request),
        .interrupt_request_pin          (interrupt_request_pin),
        .interrupt_request_register     (interrupt_request_register)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] bitv;

        // Reset held low: level mode with all pins high.
        reset_n                        = 1'b0;
        level_or_edge_triggered_config = 1'b1;
        freeze                         = 1'b0;
        clear_interrupt_request        = 8'h00;
        interrupt_request_pin          = 8'hFF;
        #1;
        chk_val("rst_async", interrupt_request_register, 8'h00);
        tick();
        tick();
        chk_val("rst_hold", interrupt_request_register, 8'h00);
        reset_n = 1'b1;
        tick();
        chk_val("rst_release", interrupt_request_register, 8'hFF);

        // Level-mode walk, with a clear pulse on each bit.
        for (int n = 0; n < 8; n++) begin
            bitv = 8'h01 << n;
            interrupt_request_pin = bitv;
            tick();
            chk_val("lvl_set", interrupt_request_register, bitv);
            clear_interrupt_request = bitv;
            tick();
            chk_val("lvl_clr", interrupt_request_register, 8'h00);
            clear_interrupt_request = 8'h00;
            tick();
            chk_val("lvl_reassert", interrupt_request_register, bitv);
        end
        interrupt_request_pin = 8'h00;
        tick();
        chk_val("lvl_drop", interrupt_request_register, 8'h00);

        // Edge-mode walk from IR7 down to IR0.
        level_or_edge_triggered_config = 1'b0;
        for (int n = 7; n >= 0; n--) begin
            bitv = 8'h01 << n;
            interrupt_request_pin = 8'h00;
            tick();
            interrupt_request_pin = bitv;
            tick();
            chk_val("edge_set", interrupt_request_register, bitv);
            tick();
            chk_val("edge_hold", interrupt_request_register, bitv);
        end

        // Clear while the pin stays high: the bit stays 0 until the pin toggles.
        clear_interrupt_request = 8'hFF;
        tick();
        chk_val("edge_clr", interrupt_request_register, 8'h00);
        clear_interrupt_request = 8'h00;
        tick();
        chk_val("edge_clr_stay", interrupt_request_register, 8'h00);
        interrupt_request_pin = 8'h00;
        tick();
        chk_val("edge_low", interrupt_request_register, 8'h00);
        interrupt_request_pin = 8'h01;
        tick();
        chk_val("edge_rearm", interrupt_request_register, 8'h01);

        // Pin drops without a clear; the latch stays armed for the next high.
        interrupt_request_pin = 8'h00;
        tick();
        chk_val("edge_drop", interrupt_request_register, 8'h00);
        interrupt_request_pin = 8'h01;
        tick();
        chk_val("edge_again", interrupt_request_register, 8'h01);

        // Clear arrives on the same edge as a rising pin.
        interrupt_request_pin = 8'h00;
        tick();
        interrupt_request_pin   = 8'h02;
        clear_interrupt_request = 8'h02;
        tick();
        chk_val("edge_clr_rise", interrupt_request_register, 8'h00);
        clear_interrupt_request = 8'h00;
        tick();
        chk_val("edge_disarmed", interrupt_request_register, 8'h00);

        // Pin high straight out of reset in edge mode never requests.
        reset_n               = 1'b0;
        interrupt_request_pin = 8'h01;
        #1;
        chk_val("rst_edge", interrupt_request_register, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk_val("edge_no_low", interrupt_request_register, 8'h00);

        // Freeze in level mode.
        level_or_edge_triggered_config = 1'b1;
        interrupt_request_pin          = 8'h05;
        tick();
        chk_val("frz_pre", interrupt_request_register, 8'h05);
        freeze                = 1'b1;
        interrupt_request_pin = 8'hA0;
        tick();
        chk_val("frz_hold1", interrupt_request_register, 8'h05);
        tick();
        chk_val("frz_hold2", interrupt_request_register, 8'h05);
        freeze = 1'b0;
        tick();
        chk_val("frz_release", interrupt_request_register, 8'hA0);

        // Arm latches keep updating while frozen in edge mode.
        level_or_edge_triggered_config = 1'b0;
        interrupt_request_pin          = 8'hFF;
        clear_interrupt_request        = 8'hFF;
        tick();
        chk_val("frz_disarm", interrupt_request_register, 8'h00);
        clear_interrupt_request = 8'h00;
        freeze                  = 1'b1;
        interrupt_request_pin   = 8'h00;
        tick();
        chk_val("frz_arm_hold", interrupt_request_register, 8'h00);
        freeze                = 1'b0;
        interrupt_request_pin = 8'hFF;
        tick();
        chk_val("frz_arm_edge", interrupt_request_register, 8'hFF);

        // Clear takes priority over freeze.
        level_or_edge_triggered_config = 1'b1;
        interrupt_request_pin          = 8'h03;
        tick();
        chk_val("cf_pre", interrupt_request_register, 8'h03);
        freeze                  = 1'b1;
        clear_interrupt_request = 8'h01;
        tick();
        chk_val("clr_over_frz", interrupt_request_register, 8'h02);
        freeze                  = 1'b0;
        clear_interrupt_request = 8'h00;
        tick();
        chk_val("cf_after", interrupt_request_register, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
